mips_multicycle_ctrl: RTL

- Control unit for the multicycle MIPS processor. It sits inside the `mips` wrapper alongside the datapath (`dp`).
- A Moore main FSM sequences fetch/decode/execute/memory/writeback over the shared ALU and unified memory.
- Combinational ALU decoding produces `alucontrol`.
- The PC enable is formed from FSM and branch outputs qualified by the datapath `zero` flag.

---
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Control unit for the multicycle MIPS processor.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and
// writeback over the shared ALU and unified memory. A combinational ALU decoder
// turns ALUOp/funct into alucontrol, and the PC enable combines the FSM
// write/branch strobes with the datapath zero flag.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (state -> FETCH)
//   op, funct         instruction opcode and function fields from the IR
//   zero              ALU zero flag, used only in the branch states
//   iord .. pcsrc     datapath mux selects and write strobes (Moore outputs)
//   alucontrol        ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt
//   pcen              PC register enable
//   instr_done        one-cycle pulse in the final state of each instruction
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       instr_done
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_BNE     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JUMP    = 4'd13
  } state_t;

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       pcwrite, branch, branchne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'b01;
        pcwrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here while the opcode is decoded.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BEQ;
          OP_BNE:       next_state = S_BNE;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_ORI:       next_state = S_ORIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            // Illegal opcode retires as a NOP.
            next_state = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = (state == S_BEQ);
        branchne   = (state == S_BNE);
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_IMMWB;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        zeroext    = 1'b1;
        aluop      = 2'b11;
        next_state = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b11: alucontrol = 3'b001;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010; // add, and unknown functs
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

endmodule
